// File: rtl/rv_test_mon_pkg.sv
// Shared constants and state encoding for the riscv-tests pass/fail monitor.
// Register indices follow the ABI names s10 (x26, done flag) and s11 (x27, pass flag).
package rv_test_mon_pkg;

    localparam logic [4:0]  REG_S10  = 5'd26;
    localparam logic [4:0]  REG_S11  = 5'd27;
    localparam logic [31:0] PASS_VAL = 32'h1;

    typedef enum logic [2:0] {
        RUN,
        SETTLE,
        PASS,
        FAIL,
        TMO
    } mon_state_e;

    function automatic logic is_terminal(input mon_state_e s);
        return (s == PASS) || (s == FAIL) || (s == TMO);
    endfunction

endpackage

// File: rtl/rv_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Holds at all-ones instead of wrapping.
module rv_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rv_test_result_monitor.sv
// Snoops register-file writes to s10/s11 and latches a sticky PASS/FAIL/TIMEOUT verdict.
// Verdict lands SETTLE_CYCLES+1 edges after the s10 write; no backpressure, pure observer.
module rv_test_result_monitor
    import rv_test_mon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SETTLE_CYCLES  = 5,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wb_we,
    input  logic [4:0]       wb_waddr,
    input  logic [31:0]      wb_wdata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             done_pulse,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [31:0]      s11_val
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;

    mon_state_e        state_q, state_d;
    logic [31:0]       s10_q, s11_q, s11_hold_q;
    logic              done_pulse_q, done_pulse_d;
    logic [SW-1:0]     settle_cnt;
    logic              s10_set, in_run, in_settle, settle_last, cyc_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s10_q <= '0;
            s11_q <= '0;
        end else if (clear) begin
            s10_q <= '0;
            s11_q <= '0;
        end else if (wb_we) begin
            if (wb_waddr == REG_S10) s10_q <= wb_wdata;
            if (wb_waddr == REG_S11) s11_q <= wb_wdata;
        end
    end

    assign s10_set   = (s10_q == PASS_VAL);
    assign in_settle = (state_q == SETTLE);
    assign in_run    = (state_q == RUN) || in_settle;

    rv_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_run),
        .clr   (clear),
        .cnt   (cycle_cnt)
    );

    // Restarts from zero whenever SETTLE is (re)entered or s10 drops.
    rv_sat_counter #(.W(SW)) u_settle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_settle && s10_set),
        .clr   (clear || !in_settle || !s10_set),
        .cnt   (settle_cnt)
    );

    assign settle_last = in_settle && s10_set && (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign cyc_last    = (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (cyc_last)     state_d = TMO;
                else if (s10_set) state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_last)  state_d = (s11_q == PASS_VAL) ? PASS : FAIL;
                else if (cyc_last) state_d = TMO;
                else if (!s10_set) state_d = RUN;
            end
            default: state_d = state_q;
        endcase
        if (clear) state_d = RUN;
        done_pulse_d = !is_terminal(state_q) && is_terminal(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            done_pulse_q <= 1'b0;
            s11_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            done_pulse_q <= done_pulse_d;
            if (clear)                     s11_hold_q <= '0;
            else if (!is_terminal(state_q)) s11_hold_q <= s11_q;
        end
    end

    assign pass       = (state_q == PASS);
    assign fail       = (state_q == FAIL);
    assign timeout    = (state_q == TMO);
    assign done       = pass | fail | timeout;
    assign done_pulse = done_pulse_q;
    assign s11_val    = is_terminal(state_q) ? s11_hold_q : s11_q;

endmodule

// File: tb/tb_rv_test_result_monitor.sv
// Scoreboard bench: expected verdicts are queued when a test sequence is driven
// and checked against the DUT on each done_pulse.
module tb_rv_test_result_monitor;

    localparam int TMO_C = 20;
    localparam int SET_C = 5;

    typedef struct {
        logic        p;
        logic        f;
        logic        t;
        logic [31:0] s11;
        logic [31:0] cnt;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, clear, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        done, pass, fail, timeout, done_pulse;
    logic [31:0] cycle_cnt, s11_val;

    int   cyc = 0;
    int   start_cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    rv_test_result_monitor #(
        .TIMEOUT_CYCLES (TMO_C),
        .SETTLE_CYCLES  (SET_C),
        .CNT_W          (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .done_pulse (done_pulse),
        .cycle_cnt  (cycle_cnt),
        .s11_val    (s11_val)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", 64'(done_pulse), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cycle", 64'(cyc),       64'(e.at));
                chk("pass",        64'(pass),      64'(e.p));
                chk("fail",        64'(fail),      64'(e.f));
                chk("timeout",     64'(timeout),   64'(e.t));
                chk("done",        64'(done),      64'(1));
                chk("s11_val",     64'(s11_val),   64'(e.s11));
                chk("cycle_cnt",   64'(cycle_cnt), 64'(e.cnt));
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d, output int wcyc);
        @(negedge clk);
        wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
        @(negedge clk);
        wb_we = 1'b0;
        wcyc = cyc;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic push(input logic p, input logic f, input logic t,
                        input logic [31:0] s11, input int at);
        exp_t e;
        e.p = p; e.f = f; e.t = t; e.s11 = s11;
        e.cnt = 32'(at - start_cyc);
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_verdict(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk(tag, 64'(sb.size()), 64'(0));
            sb.delete();
        end
        @(negedge clk);
        chk({tag, "_pulse_width"}, 64'(done_pulse), 64'(0));
        chk({tag, "_sticky"},      64'(done),       64'(1));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_done"},  64'(done),       64'(0));
        chk({tag, "_pass"},  64'(pass),       64'(0));
        chk({tag, "_fail"},  64'(fail),       64'(0));
        chk({tag, "_tmo"},   64'(timeout),    64'(0));
        chk({tag, "_pulse"}, 64'(done_pulse), 64'(0));
        chk({tag, "_cnt"},   64'(cycle_cnt),  64'(0));
        chk({tag, "_s11"},   64'(s11_val),    64'(0));
    endtask

    task automatic pass_seq(input string tag);
        int w;
        wr(5'd27, 32'h1, w);
        chk({tag, "_s11_follow"}, 64'(s11_val), 64'(1));
        wr(5'd26, 32'h1, w);
        push(1'b1, 1'b0, 1'b0, 32'h1, w + SET_C + 1);
        wait_verdict(tag, 20);
    endtask

    initial begin
        int w, w1, w2;
        rst_n = 1'b0; clear = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        start_cyc = cyc;

        // PASS
        pass_seq("pass1");

        // FAIL with s11 = 0
        do_clear();
        wr(5'd27, 32'h0, w);
        wr(5'd26, 32'h1, w);
        push(1'b0, 1'b1, 1'b0, 32'h0, w + SET_C + 1);
        wait_verdict("fail1", 20);

        // Aborted settle, then a fresh full settle
        do_clear();
        wr(5'd27, 32'h1, w);
        wr(5'd26, 32'h1, w1);
        wr(5'd26, 32'h0, w);
        wr(5'd26, 32'h1, w2);
        push(1'b1, 1'b0, 1'b0, 32'h1, w2 + SET_C + 1);
        wait_verdict("abort", 20);

        // Timeout, then late writes must not change the verdict
        do_clear();
        push(1'b0, 1'b0, 1'b1, 32'h0, start_cyc + TMO_C);
        wait_verdict("tmo", 30);
        wr(5'd27, 32'h1, w);
        wr(5'd26, 32'h1, w);
        repeat (SET_C + 3) @(negedge clk);
        chk("tmo_hold_pass", 64'(pass),      64'(0));
        chk("tmo_hold_tmo",  64'(timeout),   64'(1));
        chk("tmo_hold_cnt",  64'(cycle_cnt), 64'(TMO_C));

        // Ignored writes: x0, x25, and we=0 to x26
        do_clear();
        wr(5'd0,  32'h1, w);
        wr(5'd25, 32'h1, w);
        @(negedge clk);
        wb_we = 1'b0; wb_waddr = 5'd26; wb_wdata = 32'h1;
        repeat (SET_C + 3) @(negedge clk);
        chk("ign_done", 64'(done),      64'(0));
        chk("ign_s11",  64'(s11_val),   64'(0));
        chk("ign_cnt",  64'(cycle_cnt), 64'(cyc - start_cyc));

        // clear after PASS
        do_clear();
        pass_seq("pass2");
        do_clear();
        chk_idle("clear");

        // Async reset mid-SETTLE, then a clean PASS
        wr(5'd27, 32'h1, w);
        wr(5'd26, 32'h1, w);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle("arst");
        @(negedge clk);
        rst_n = 1'b1;
        start_cyc = cyc;
        pass_seq("pass3");

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t want earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv_test_result_monitor.md
Name: rv_test_result_monitor

Overview:
Synthesizable pass/fail monitor placed directly downstream of the core register file, next to regu, inside soc_core_top.
- Snoops the register-file write port and keeps shadow copies of s10 (x26, "test done") and s11 (x27, "test pass").
- Declares PASS, FAIL or TIMEOUT using the riscv-tests convention.
- Lets benches and FPGA builds read a verdict from status pins instead of probing x_reg hierarchically.

Parameters:
- TIMEOUT_CYCLES, 1000, number of RUN/SETTLE cycles before TIMEOUT is declared.
- SETTLE_CYCLES, 5, number of consecutive cycles s10 must stay 1 before s11 is sampled.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous re-arm: returns to RUN and zeroes the shadows and counters.
- wb_we  input  1  register-file write enable (snooped).
- wb_waddr  input  5  register-file write address.
- wb_wdata  input  32  register-file write data.
- done  output  1  sticky; a verdict has been reached.
- pass  output  1  sticky; s11==1 at evaluation.
- fail  output  1  sticky; s11!=1 at evaluation.
- timeout  output  1  sticky; the cycle budget was exhausted.
- done_pulse  output  1  one-cycle strobe on the cycle done rises.
- cycle_cnt  output  CNT_W  cycles spent in RUN+SETTLE; saturates at all-ones.
- s11_val  output  32  s11 shadow value, frozen at the verdict.

Behaviour:
Clock and reset
- One clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values: every output is 0, both shadows are 0, state is RUN, settle_cnt is 0.

Shadow registers
- A shadow updates on the clock edge where wb_we=1 and wb_waddr matches (26 for s10, 27 for s11).
- Writes to x0 and to any other address are ignored.
- A write is visible in the shadow one cycle after it is presented; FSM decisions always use the registered shadow.

FSM states: RUN, SETTLE, PASS, FAIL, TMO.
- RUN → SETTLE when shadow_s10==1; settle_cnt is set to 0.
- SETTLE, while shadow_s10 stays 1: settle_cnt increments each cycle.
- SETTLE → RUN if shadow_s10 becomes anything other than 1.
- Verdict: when settle_cnt==SETTLE_CYCLES-1 and shadow_s10 is still 1, go to PASS if shadow_s11==1, else FAIL.
- SETTLE therefore lasts exactly SETTLE_CYCLES cycles before the verdict.
- RUN or SETTLE → TMO when cycle_cnt==TIMEOUT_CYCLES-1 and no verdict is due that cycle.
- If the verdict and the timeout fall on the same cycle, the verdict wins.
- PASS, FAIL and TMO are terminal. They are left only by rst_n or clear.

Outputs and counters
- Each output flag (done, pass, fail, timeout) is registered and rises on the edge that enters its state.
- done = pass | fail | timeout. Exactly one of pass, fail, timeout is ever 1.
- done_pulse is high for the first cycle of a terminal state only.
- cycle_cnt increments in RUN and SETTLE, holds in terminal states, and saturates at all-ones; it never wraps.
- s11_val follows the s11 shadow until the verdict, then holds.

clear and reset
- clear has priority over snooping and the FSM in the same cycle.
- clear zeroes the shadows, counters and flags and sets state to RUN. Any write arriving on the clear cycle is dropped.
- Asserting rst_n low mid-test aborts immediately to reset values, with no pulse.

Decomposition:
- Package rv_test_mon_pkg holds the constants REG_S10=5'd26 and REG_S11=5'd27, the state enum {RUN, SETTLE, PASS, FAIL, TMO}, and the PASS_VAL=32'h1 constant. define.v `s10/`s11 are mapped onto these constants.
- One sub-module, rv_sat_counter (parameter W, inputs inc/clr, saturating), is reused for both cycle_cnt and settle_cnt.
- The FSM and shadows stay in the top module.

Test Plan:
- Write s11=1, then s10=1; hold 5 cycles → pass=1, done=1, done_pulse high for 1 cycle exactly SETTLE_CYCLES+1 cycles after the s10 write; s11_val=32'h1.
- Write s11=0, then s10=1 → fail=1, pass=0, s11_val=0.
- Write s10=1, then s10=0 two cycles later, then s10=1 again → first SETTLE is aborted, verdict comes only after a fresh 5-cycle settle; cycle_cnt matches the elapsed cycles.
- Never write s10, TIMEOUT_CYCLES=20 → timeout=1 at cycle_cnt=20; pass/fail stay 0. s10 writes afterwards do not change the verdict.
- Writes with wb_waddr=0 or 25 carrying 32'h1, and wb_we=0 with waddr=26 → shadows stay 0 and no SETTLE is entered.
- Assert clear after PASS, and rst_n low mid-SETTLE → all outputs 0 next cycle (async for rst_n); a new PASS sequence completes normally afterwards.
